systolic_result_collector: RTL and testbench

- Sits at the bottom edge of systolic_array_4_4 and receives its skewed, column-staggered outputs (array_en_down_3_c / array_data_down_3_c).
- De-skews the four columns into aligned result rows and buffers them in a small FIFO.
- Presents each row to the downstream NICE writeback logic over a valid/ready handshake.
- Tracks a configured number of expected rows per job and flags done, overflow and skew errors.

---
 rtl/systolic_result_collector.sv | 131 +++++++++++++
 tb/tb_systolic_result_collector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_collector.sv
// systolic_result_collector: de-skews systolic array bottom-edge columns into aligned rows, buffers them in a FIFO
// and hands them downstream over valid/ready; COLLECTOR_RELU_EN clamps negative elements to zero at FIFO write.
module systolic_result_collector #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int ROW_CNT_W  = 8
) (
   input  logic                  array_clk,
   input  logic                  array_rst,
   input  logic                  start,
   input  logic [ROW_CNT_W-1:0]  cfg_rows,
   input  logic                  array_en_down_3_0,
   input  logic                  array_en_down_3_1,
   input  logic                  array_en_down_3_2,
   input  logic                  array_en_down_3_3,
   input  logic [DATA_WIDTH-1:0] array_data_down_3_0,
   input  logic [DATA_WIDTH-1:0] array_data_down_3_1,
   input  logic [DATA_WIDTH-1:0] array_data_down_3_2,
   input  logic [DATA_WIDTH-1:0] array_data_down_3_3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data_0,
   output logic [DATA_WIDTH-1:0] out_data_1,
   output logic [DATA_WIDTH-1:0] out_data_2,
   output logic [DATA_WIDTH-1:0] out_data_3,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  skew_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef logic [3:0][DATA_WIDTH-1:0] row_t;
   typedef enum logic [1:0] {IDLE, COLLECT, FINISH} state_t;

   state_t                      state, state_nx;
   logic [2:0]                  en0_q;
   logic [1:0]                  en1_q;
   logic                        en2_q;
   logic [2:0][DATA_WIDTH-1:0]  d0_q;
   logic [1:0][DATA_WIDTH-1:0]  d1_q;
   logic [DATA_WIDTH-1:0]       d2_q;
   logic [3:0]                  a_en;
   row_t                        a_data, w_data, head;
   row_t                        mem [FIFO_DEPTH];
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic [ROW_CNT_W-1:0]        cnt, cnt_nx, cfg_q;
   logic                        collecting, row_ok, mixed, full, pop, push, drop;

   // Column c sees 3-c delay stages so all four columns line up with column 3.
   always_ff @(posedge array_clk or posedge array_rst)
      if (array_rst) begin
         en0_q <= '0;
         en1_q <= '0;
         en2_q <= 1'b0;
         d0_q  <= '0;
         d1_q  <= '0;
         d2_q  <= '0;
      end else begin
         en0_q <= {en0_q[1:0], array_en_down_3_0};
         en1_q <= {en1_q[0], array_en_down_3_1};
         en2_q <= array_en_down_3_2;
         d0_q  <= {d0_q[1:0], array_data_down_3_0};
         d1_q  <= {d1_q[0], array_data_down_3_1};
         d2_q  <= array_data_down_3_2;
      end

   assign a_en   = {array_en_down_3_3, en2_q, en1_q[1], en0_q[2]};
   assign a_data = {array_data_down_3_3, d2_q, d1_q[1], d0_q[2]};

`ifdef COLLECTOR_RELU_EN
   always_comb begin
      w_data = a_data;
      for (int c = 0; c < 4; c++)
         if (a_data[c][DATA_WIDTH-1]) w_data[c] = '0;
   end
`else
   assign w_data = a_data;
`endif

   assign collecting = state == COLLECT;
   assign row_ok     = &a_en;
   assign mixed      = |a_en & ~row_ok;
   assign out_valid  = wr_ptr != rd_ptr;
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = out_valid & out_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts the row.
   assign push       = collecting & row_ok & (~full | pop);
   assign drop       = collecting & row_ok & full & ~pop;
   assign cnt_nx     = cnt + ROW_CNT_W'(push);
   assign head       = mem[rd_ptr[AW-1:0]];
   assign out_data_0 = head[0];
   assign out_data_1 = head[1];
   assign out_data_2 = head[2];
   assign out_data_3 = head[3];
   assign busy       = collecting;
   assign done       = state == FINISH;

   always_comb begin
      state_nx = state;
      if (start) state_nx = (cfg_rows == '0) ? FINISH : COLLECT;
      else if (collecting && cnt_nx == cfg_q) state_nx = FINISH;
   end

   always_ff @(posedge array_clk or posedge array_rst)
      if (array_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         cfg_q    <= '0;
         overflow <= 1'b0;
         skew_err <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= start ? '0 : cnt_nx;
         cfg_q    <= start ? cfg_rows : cfg_q;
         overflow <= ~start & (overflow | drop);
         skew_err <= ~start & (skew_err | (collecting & mixed));
         wr_ptr   <= wr_ptr + PW'(push);
         rd_ptr   <= rd_ptr + PW'(pop);
      end

   always_ff @(posedge array_clk or posedge array_rst)
      if (array_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr[AW-1:0]] <= w_data;
      end
endmodule

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector: directed table plus randomized jobs against a queue-based reference model.
module tb_systolic_result_collector;
   localparam int DW = 32;
   localparam int D  = 2;
   localparam int RW = 8;

   typedef logic [3:0][DW-1:0] row_t;
   typedef struct {
      row_t row;
      row_t exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst, start, out_ready;
   logic [RW-1:0] cfg_rows;
   logic [3:0]    en;
   row_t          din;
   logic          out_valid, busy, done, overflow, skew_err;
   logic [DW-1:0] o0, o1, o2, o3;

   int   checks = 0;
   int   failures = 0;
   logic [3:0] s_en [64];
   row_t s_d [64];
   bit   s_row [64];
   row_t s_rd [64];
   row_t got [$];
   row_t q [$];
   vec_t tbl [4];
   bit   saw_valid;
   int   first_valid;

   always #5 clk = ~clk;

   systolic_result_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .ROW_CNT_W(RW)) dut (
      .array_clk(clk), .array_rst(rst), .start(start), .cfg_rows(cfg_rows),
      .array_en_down_3_0(en[0]), .array_en_down_3_1(en[1]),
      .array_en_down_3_2(en[2]), .array_en_down_3_3(en[3]),
      .array_data_down_3_0(din[0]), .array_data_down_3_1(din[1]),
      .array_data_down_3_2(din[2]), .array_data_down_3_3(din[3]),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data_0(o0), .out_data_1(o1), .out_data_2(o2), .out_data_3(o3),
      .busy(busy), .done(done), .overflow(overflow), .skew_err(skew_err)
   );

   function automatic row_t mk(input int a, input int b, input int c, input int d);
      row_t r;
      r[0] = a;
      r[1] = b;
      r[2] = c;
      r[3] = d;
      return r;
   endfunction

   function automatic row_t relu(input row_t r);
      row_t x = r;
`ifdef COLLECTOR_RELU_EN
      for (int c = 0; c < 4; c++) if (x[c][DW-1]) x[c] = '0;
`endif
      return x;
   endfunction

   function row_t outrow();
      return {o3, o2, o1, o0};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_sched();
      for (int t = 0; t < 64; t++) begin
         s_en[t]  = '0;
         s_d[t]   = '0;
         s_row[t] = 1'b0;
         s_rd[t]  = '0;
      end
   endtask

   // Column c of a row based at cycle 'base' arrives at base+c; 'late' delays one column by a cycle.
   task automatic put_row(input int base, input row_t r, input int late);
      for (int c = 0; c < 4; c++) begin
         int t = base + c + ((c == late) ? 1 : 0);
         s_en[t][c] = 1'b1;
         s_d[t][c]  = r[c];
      end
      s_row[base] = (late < 0);
      s_rd[base]  = r;
   endtask

   task automatic drive(input int i);
      if (i < 64) begin
         en  = s_en[i];
         din = s_d[i];
      end else begin
         en  = '0;
         din = '0;
      end
   endtask

   task automatic run(input int n, input bit rdy);
      saw_valid   = 1'b0;
      first_valid = -1;
      for (int i = 0; i < n; i++) begin
         out_ready = rdy;
         drive(i);
         @(negedge clk);
         if (out_valid) begin
            saw_valid = 1'b1;
            if (first_valid < 0) first_valid = i;
            if (rdy) got.push_back(outrow());
         end
         @(posedge clk);
         #1;
      end
      drive(64);
   endtask

   task automatic do_start(input int cfg);
      start     = 1'b1;
      cfg_rows  = RW'(cfg);
      out_ready = 1'b0;
      drive(64);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic rand_job();
      int cfg, nr, b, n, cnt;
      bit coll, dn, ovf, pop, room;
      cfg = $urandom_range(0, 10);
      nr  = $urandom_range(0, 12);
      b   = 0;
      clear_sched();
      for (int k = 0; k < nr; k++) begin
         b += $urandom_range(1, 3);
         put_row(b, mk($urandom, $urandom, $urandom, $urandom), -1);
      end
      n = b + 9;
      do_start(cfg);
      coll = (cfg != 0);
      dn   = (cfg == 0);
      ovf  = 1'b0;
      cnt  = 0;
      for (int i = 0; i < n; i++) begin
         out_ready = ($urandom_range(0, 2) != 0);
         drive(i);
         @(negedge clk);
         chk("rnd_valid", out_valid, q.size() != 0);
         if (q.size() != 0) chk("rnd_data", outrow(), q[0]);
         chk("rnd_done", done, dn);
         chk("rnd_overflow", overflow, ovf);
         chk("rnd_busy", busy, coll);
         pop  = out_ready && q.size() != 0;
         room = q.size() < D || pop;
         if (pop) void'(q.pop_front());
         if (coll && i >= 3 && s_row[i-3]) begin
            if (room) begin
               q.push_back(relu(s_rd[i-3]));
               cnt++;
               if (cnt == cfg) begin
                  coll = 1'b0;
                  dn   = 1'b1;
               end
            end else ovf = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      drive(64);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; cfg_rows = '0; en = '0; din = '0;
      tbl[0] = '{mk(214, 236, 268, 300), mk(214, 236, 268, 300)};
      tbl[1] = '{mk(240, 266, 304, 342), mk(240, 266, 304, 342)};
      tbl[2] = '{mk(266, 296, 340, 384), mk(266, 296, 340, 384)};
`ifdef COLLECTOR_RELU_EN
      tbl[3] = '{mk(-5, 0, 7, -1), mk(0, 0, 7, 0)};
`else
      tbl[3] = '{mk(-5, 0, 7, -1), mk(-5, 0, 7, -1)};
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_skew", skew_err, 0);
      chk("rst_data", outrow(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      clear_sched();
      put_row(0, tbl[0].row, -1);
      run(8, 1);
      chk("idle_no_valid", saw_valid, 0);
      chk("idle_busy", busy, 0);

      do_start(4);
      clear_sched();
      for (int k = 0; k < 4; k++) put_row(k, tbl[k].row, -1);
      got.delete();
      run(12, 1);
      chk("table_count", got.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < got.size()) chk($sformatf("table_row%0d", k), got[k], tbl[k].exp);
      chk("table_latency", first_valid, 4);
      chk("table_done", done, 1);
      chk("table_busy", busy, 0);
      chk("table_overflow", overflow, 0);
      chk("table_skew", skew_err, 0);

      clear_sched();
      put_row(0, tbl[1].row, -1);
      got.delete();
      run(8, 1);
      chk("after_done_no_valid", saw_valid, 0);
      chk("after_done_done", done, 1);

      do_start(0);
      chk("cfg0_done", done, 1);
      chk("cfg0_busy", busy, 0);

      do_start(3);
      clear_sched();
      for (int k = 0; k < 3; k++) put_row(k, tbl[k].row, -1);
      got.delete();
      run(10, 0);
      chk("stall_overflow", overflow, 1);
      chk("stall_done", done, 0);
      chk("stall_busy", busy, 1);
      chk("stall_valid", out_valid, 1);
      chk("stall_head", outrow(), tbl[0].exp);
      clear_sched();
      for (int k = 0; k < 3; k++) begin
         run(1, 0);
         chk("stall_stable", outrow(), tbl[0].exp);
      end
      got.delete();
      run(6, 1);
      chk("release_count", got.size(), 2);
      if (got.size() >= 2) begin
         chk("release_row0", got[0], tbl[0].exp);
         chk("release_row1", got[1], tbl[1].exp);
      end
      chk("release_empty", out_valid, 0);
      chk("release_done", done, 0);

      do_start(2);
      clear_sched();
      put_row(0, tbl[0].row, 2);
      put_row(6, tbl[1].row, -1);
      got.delete();
      run(14, 1);
      chk("skew_flag", skew_err, 1);
      chk("skew_count", got.size(), 1);
      if (got.size() >= 1) chk("skew_row", got[0], tbl[1].exp);
      chk("skew_done", done, 0);
      chk("skew_busy", busy, 1);
      clear_sched();
      put_row(0, tbl[2].row, -1);
      run(8, 1);
      chk("skew_count2", got.size(), 2);
      if (got.size() >= 2) chk("skew_row2", got[1], tbl[2].exp);
      chk("skew_done2", done, 1);
      chk("skew_sticky", skew_err, 1);

      do_start(3);
      clear_sched();
      put_row(0, tbl[0].row, 1);
      put_row(4, tbl[1].row, -1);
      run(10, 0);
      chk("pre_rst_skew", skew_err, 1);
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #2;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_overflow", overflow, 0);
      chk("mid_rst_skew", skew_err, 0);
      chk("mid_rst_data", outrow(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();

      repeat (25) rand_job();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
